// File: rtl/game_pkg.sv
// Shared game-side definitions: coordinate width, map colours, screen bounds
// and the probe FSM state encoding.
package game_pkg;

  localparam int unsigned COORD_W     = 9;
  localparam int unsigned OFFSET_W    = 4;
  localparam int unsigned MAP_LATENCY = 2;

  localparam int unsigned SCREEN_W = 512;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t RED   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } probe_state_e;

  // One extra bit so a probe that runs off the coordinate space is detectable.
  function automatic logic [COORD_W:0] coord_sum(input logic [COORD_W-1:0] base,
                                                 input logic [OFFSET_W-1:0] off);
    return {1'b0, base} + {{(COORD_W + 1 - OFFSET_W){1'b0}}, off};
  endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Request/result and trap-map query signals of the collision probe.
interface collision_probe_if;

  logic                         start;
  logic [game_pkg::COORD_W-1:0] robo_x;
  logic [game_pkg::COORD_W-1:0] robo_y;
  logic [game_pkg::COORD_W-1:0] x_cord;
  logic [game_pkg::COORD_W-1:0] y_cord;
  game_pkg::colour_t            flag;
  logic                         busy;
  logic                         done;
  logic                         hit;
  logic [game_pkg::COORD_W-1:0] hit_x;
  logic [game_pkg::COORD_W-1:0] hit_y;

  modport master (
    output start, robo_x, robo_y, flag,
    input  x_cord, y_cord, busy, done, hit, hit_x, hit_y
  );

  modport slave (
    input  start, robo_x, robo_y, flag,
    output x_cord, y_cord, busy, done, hit, hit_x, hit_y
  );

endinterface

// File: rtl/probe_tag_pipe.sv
// Delay line carrying {valid, x, y} for each probe so it lines up with the
// colour the trap map returns DEPTH edges later.
module probe_tag_pipe
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_vld,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_vld,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
);

  logic               vld_p [DEPTH];
  logic [COORD_W-1:0] x_p   [DEPTH];
  logic [COORD_W-1:0] y_p   [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i] <= 1'b0;
        x_p[i]   <= '0;
        y_p[i]   <= '0;
      end
    end else begin
      vld_p[0] <= in_vld;
      x_p[0]   <= in_x;
      y_p[0]   <= in_y;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        x_p[i]   <= x_p[i-1];
        y_p[i]   <= y_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[DEPTH-1];
  assign out_x   = x_p[DEPTH-1];
  assign out_y   = y_p[DEPTH-1];

endmodule

// File: rtl/collision_probe.sv
// Scans the robot bounding box pixel by pixel against the trap map and reports
// whether any pixel is a hit colour, keeping the first hit in scan order.
module collision_probe
  import game_pkg::*;
#(
  parameter int unsigned ROBO_W     = 8,
  parameter int unsigned ROBO_H     = 8,
  parameter colour_t     HIT_COLOUR = RED
) (
  input  logic               clock,
  input  logic               reset,
  collision_probe_if.slave   bus
);

  localparam int unsigned        N_PROBES = ROBO_W * ROBO_H;
  localparam logic [OFFSET_W-1:0] DX_LAST = OFFSET_W'(ROBO_W - 1);
  localparam logic [OFFSET_W-1:0] DY_LAST = OFFSET_W'(ROBO_H - 1);

  probe_state_e        state, state_n;
  logic [OFFSET_W-1:0] dx, dy, dx_n, dy_n;
  logic [COORD_W-1:0]  base_x, base_y, probe_bx, probe_by;
  logic                drain_cnt;
  logic                load, issue, finish;
  logic [COORD_W:0]    sum_x, sum_y;
  logic                probe_vld;

  logic               tag_vld;
  logic [COORD_W-1:0] tag_x, tag_y;

  logic               busy_r, done_r, hit_r;
  logic [COORD_W-1:0] x_cord_r, y_cord_r, hit_x_r, hit_y_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    issue    = 1'b0;
    finish   = 1'b0;
    dx_n     = dx;
    dy_n     = dy;
    probe_bx = base_x;
    probe_by = base_y;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          issue    = 1'b1;
          dx_n     = '0;
          dy_n     = '0;
          probe_bx = bus.robo_x;
          probe_by = bus.robo_y;
          state_n  = (N_PROBES == 1) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (dx == DX_LAST) begin
          dx_n = '0;
          dy_n = dy + OFFSET_W'(1);
        end else begin
          dx_n = dx + OFFSET_W'(1);
        end
        // Leave SCAN on the same edge that registers the final probe.
        if (dx_n == DX_LAST && dy_n == DY_LAST) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sum_x     = coord_sum(probe_bx, dx_n);
  assign sum_y     = coord_sum(probe_by, dy_n);
  assign probe_vld = issue && !sum_x[COORD_W] && !sum_y[COORD_W];

  // Stage p0: probe registered towards the map, tag enters the delay line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_x    <= '0;
      base_y    <= '0;
      dx        <= '0;
      dy        <= '0;
      x_cord_r  <= '0;
      y_cord_r  <= '0;
      drain_cnt <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r    <= finish;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (load) begin
        base_x <= bus.robo_x;
        base_y <= bus.robo_y;
        busy_r <= 1'b1;
      end else if (finish) begin
        busy_r <= 1'b0;
      end
      if (issue) begin
        dx       <= dx_n;
        dy       <= dy_n;
        x_cord_r <= sum_x[COORD_W-1:0];
        y_cord_r <= sum_y[COORD_W-1:0];
      end
    end
  end

  probe_tag_pipe #(
    .DEPTH (MAP_LATENCY)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (probe_vld),
    .in_x    (sum_x[COORD_W-1:0]),
    .in_y    (sum_y[COORD_W-1:0]),
    .out_vld (tag_vld),
    .out_x   (tag_x),
    .out_y   (tag_y)
  );

  // Stage p2: returned colour meets its tag; only the first hit is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_r   <= 1'b0;
      hit_x_r <= '0;
      hit_y_r <= '0;
    end else if (load) begin
      hit_r   <= 1'b0;
      hit_x_r <= '0;
      hit_y_r <= '0;
    end else if (tag_vld && bus.flag == HIT_COLOUR && !hit_r) begin
      hit_r   <= 1'b1;
      hit_x_r <= tag_x;
      hit_y_r <= tag_y;
    end
  end

  assign bus.x_cord = x_cord_r;
  assign bus.y_cord = y_cord_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.hit    = hit_r;
  assign bus.hit_x  = hit_x_r;
  assign bus.hit_y  = hit_y_r;

endmodule

// File: tb/tb_collision_probe.sv
// Bench for collision_probe: synthetic trap maps, a scan-level reference model
// and a per-cycle compare of every output.
module tb_collision_probe;
  import game_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic clock = 1'b0;
  logic reset;

  collision_probe_if bus ();

  collision_probe #(
    .ROBO_W     (W),
    .ROBO_H     (H),
    .HIT_COLOUR (RED)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int map_mode = 0;
  int cyc      = 0;

  bit m_act = 1'b0;
  int m_s, m_bx, m_by, m_hidx, m_hx, m_hy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synthetic trap maps: 0 = level with lava and spikes, 1 = red strip x<8, 2 = sparse pattern.
  function automatic colour_t map_colour(input int x, input int y, input int mode);
    if (mode == 1) return (x < 8) ? RED : BLACK;
    if (mode == 2) begin
      if ((x * 7 + y * 13) % 53 == 0) return RED;
      return ((x + y) % 5 == 0) ? 3'b101 : BLACK;
    end
    if (x >= 96 && x <= 159 && y >= 236 && y <= 255) return RED;
    if (y >= 186 && y <= 190 && x >= 60 && x <= 90) return RED;
    if (y >= 181 && y <= 185 && x >= 40 && x <= 100) return BLACK;
    if (x >= 200 && x <= 230 && y >= 300) return 3'b110;
    return 3'b010;
  endfunction

  always @(posedge clock) bus.flag <= map_colour(bus.x_cord, bus.y_cord, map_mode);

  // Reference: scan the whole box in row-major order, skip off-space pixels.
  task automatic model_scan(input int bx, input int by, output int hidx, output int hx, output int hy);
    hidx = -1; hx = 0; hy = 0;
    for (int dy = 0; dy < H; dy++)
      for (int dx = 0; dx < W; dx++)
        if (hidx < 0 && bx + dx <= 511 && by + dy <= 511 &&
            map_colour(bx + dx, by + dy, map_mode) == RED) begin
          hidx = dy * W + dx; hx = bx + dx; hy = by + dy;
        end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act = 1'b0;
    end else begin
      cyc++;
      if (bus.start && (!m_act || cyc >= m_s + N + 2)) begin
        m_act = 1'b1;
        m_s   = cyc;
        m_bx  = bus.robo_x;
        m_by  = bus.robo_y;
        model_scan(m_bx, m_by, m_hidx, m_hx, m_hy);
      end
    end
  end

  always @(negedge clock) begin : compare
    int d, p;
    logic e_busy, e_done, e_hit;
    int e_hx, e_hy, e_x, e_y;
    if (!reset) begin
      e_busy = 0; e_done = 0; e_hit = 0; e_hx = 0; e_hy = 0; e_x = 0; e_y = 0;
      if (m_act) begin
        d      = cyc - m_s;
        p      = (d < N - 1) ? d : N - 1;
        e_busy = (d <= N);
        e_done = (d == N + 1);
        e_hit  = (m_hidx >= 0) && (d >= m_hidx + 2);
        e_hx   = e_hit ? m_hx : 0;
        e_hy   = e_hit ? m_hy : 0;
        e_x    = (m_bx + p % W) & 511;
        e_y    = (m_by + p / W) & 511;
      end
      chk("busy",   32'(bus.busy),   32'(e_busy));
      chk("done",   32'(bus.done),   32'(e_done));
      chk("hit",    32'(bus.hit),    32'(e_hit));
      chk("hit_x",  32'(bus.hit_x),  e_hx);
      chk("hit_y",  32'(bus.hit_y),  e_hy);
      chk("x_cord", 32'(bus.x_cord), e_x);
      chk("y_cord", 32'(bus.y_cord), e_y);
    end
  end

  task automatic run_scan(input logic [8:0] bx, input logic [8:0] by, input bit spam,
                          input int inject, output int lat);
    int s;
    @(negedge clock);
    bus.robo_x = bx; bus.robo_y = by; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    s   = cyc;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.done) begin
        lat = cyc - s;
        break;
      end
      if (i == inject + 1) chk("busy_after_ignored_start", 32'(bus.busy), 32'd1);
      if (i == inject) begin
        bus.robo_x = 9'd100; bus.robo_y = 9'd240; bus.start = 1'b1;
      end else if (spam) begin
        bus.robo_x = 9'($urandom);
        bus.robo_y = 9'($urandom);
        bus.start  = bus.busy && ($urandom_range(7) == 0);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
  endtask

  initial begin : stim
    int lat;
    logic [8:0] rx, ry;
    reset = 1'b1; bus.start = 1'b0; bus.robo_x = '0; bus.robo_y = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_hit",    32'(bus.hit),    32'd0);
    chk("rst_x_cord", 32'(bus.x_cord), 32'd0);
    chk("rst_y_cord", 32'(bus.y_cord), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    map_mode = 0;
    run_scan(9'd10, 9'd10, 1'b0, -1, lat);
    chk("lat_10_10", lat, 32'd65);
    chk("hit_10_10", 32'(bus.hit), 32'd0);
    chk("hx_10_10",  32'(bus.hit_x), 32'd0);
    chk("hy_10_10",  32'(bus.hit_y), 32'd0);

    run_scan(9'd100, 9'd240, 1'b0, -1, lat);
    chk("hit_lava", 32'(bus.hit),   32'd1);
    chk("hx_lava",  32'(bus.hit_x), 32'd100);
    chk("hy_lava",  32'(bus.hit_y), 32'd240);

    run_scan(9'd55, 9'd181, 1'b0, -1, lat);
    chk("hit_spike",   32'(bus.hit),   32'd1);
    chk("hx_spike",    32'(bus.hit_x), 32'd60);
    chk("hy_spike",    32'(bus.hit_y), 32'd186);
    chk("model_spike", m_hidx, 32'd45);

    map_mode = 1;
    run_scan(9'd508, 9'd0, 1'b0, -1, lat);
    chk("hit_wrap",    32'(bus.hit),    32'd0);
    chk("hold_x_wrap", 32'(bus.x_cord), 32'd3);
    chk("hold_y_wrap", 32'(bus.y_cord), 32'd7);
    run_scan(9'd0, 9'd0, 1'b0, -1, lat);
    chk("hit_origin", 32'(bus.hit),   32'd1);
    chk("hx_origin",  32'(bus.hit_x), 32'd0);
    chk("hy_origin",  32'(bus.hit_y), 32'd0);

    map_mode = 0;
    run_scan(9'd55, 9'd181, 1'b0, 19, lat);
    chk("lat_ignored", lat, 32'd65);
    chk("hx_ignored",  32'(bus.hit_x), 32'd60);
    chk("hy_ignored",  32'(bus.hit_y), 32'd186);

    // Reset in the middle of a scan that has already hit.
    @(negedge clock);
    bus.robo_x = 9'd100; bus.robo_y = 9'd240; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (29) @(negedge clock);
    chk("pre_rst_hit", 32'(bus.hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy",   32'(bus.busy),   32'd0);
    chk("midrst_done",   32'(bus.done),   32'd0);
    chk("midrst_hit",    32'(bus.hit),    32'd0);
    chk("midrst_x_cord", 32'(bus.x_cord), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run_scan(9'd100, 9'd240, 1'b0, -1, lat);
    chk("lat_after_rst", lat, 32'd65);
    chk("hx_after_rst",  32'(bus.hit_x), 32'd100);

    map_mode = 2;
    for (int k = 0; k < 40; k++) begin
      rx = 9'($urandom);
      ry = 9'($urandom);
      if (k % 4 == 0) rx = 9'(504 + $urandom_range(7));
      if (k % 5 == 0) ry = 9'(504 + $urandom_range(7));
      run_scan(rx, ry, 1'b1, -1, lat);
      chk("lat_rand", lat, N + 1);
      repeat ($urandom_range(3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
